// File: rtl/alu_retire_stage.sv
// Retire stage behind the 20-bit ALU: register file writeback, 4-bit status, jump resolution and trap mode.
// Optional build macro RETIRE_COUNT_EN adds a 16-bit wrapping count of accepted requests (retire_cnt).

module alu_retire_reg #(
  parameter int DATA_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);
  logic [DATA_W-1:0] q_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q_q <= '0;
    else if (we_i) q_q <= d_i;
  end

  assign q_o = q_q;
endmodule

module alu_retire_stage #(
  parameter int DATA_W = 20,
  parameter int NREG   = 8,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [REG_AW-1:0] in_dest,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_flag_we,
  input  logic [3:0]        in_flags,
  input  logic [REG_AW-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [3:0]        status,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_target,
  output logic              trap,
`ifdef RETIRE_COUNT_EN
  output logic [15:0]       retire_cnt,
`endif
  input  logic              trap_clr
);
  localparam logic [2:0] K_WB  = 3'd0, K_LSR = 3'd1, K_XSR = 3'd2, K_JMP = 3'd3,
                         K_JZ  = 3'd4, K_JS  = 3'd5, K_JZS = 3'd6, K_TRAP = 3'd7;

  typedef enum logic [1:0] {RUN, FLUSH, TRAP} state_t;

  state_t                       state_q, state_d;
  logic [3:0]                   status_q, status_d;
  logic                         br_taken_q;
  logic [DATA_W-1:0]            br_target_q;
  logic [NREG-1:0][DATA_W-1:0]  regs_q;

  logic acc, wb_we, take;

  assign in_ready = (state_q == RUN);
  assign acc      = in_valid && in_ready;
  assign wb_we    = acc && (in_kind == K_WB);

  // Jump condition sees the status held before this instruction retires.
  always_comb begin
    take = 1'b0;
    if (acc) begin
      unique case (in_kind)
        K_JMP:   take = 1'b1;
        K_JZ:    take = status_q[0];
        K_JS:    take = status_q[2];
        K_JZS:   take = status_q[0] | status_q[2];
        default: take = 1'b0;
      endcase
    end
  end

  always_comb begin
    status_d = status_q;
    if (acc) begin
      unique case (in_kind)
        K_WB:    if (in_flag_we) status_d = in_flags;
        K_LSR:   status_d = in_result[3:0];
        K_XSR:   status_d = status_q ^ in_result[3:0];
        default: status_d = status_q;
      endcase
    end
  end

  // Trap entry only happens from RUN and trap_clr only acts in TRAP, so entry always wins.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (acc && in_kind == K_TRAP) state_d = TRAP;
        else if (take)                state_d = FLUSH;
      end
      FLUSH:   state_d = RUN;
      TRAP:    if (trap_clr) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      status_q    <= '0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      br_taken_q <= take;
      if (take) br_target_q <= in_result;
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_reg
    alu_retire_reg #(.DATA_W(DATA_W)) u_reg (
      .clk  (clk),
      .rst  (rst),
      .we_i (wb_we && (in_dest == REG_AW'(g))),
      .d_i  (in_result),
      .q_o  (regs_q[g])
    );
  end

  // Write-first: a same-cycle writeback to the read address is forwarded.
  assign rd_data   = (wb_we && in_dest == rd_addr) ? in_result : regs_q[rd_addr];
  assign status    = status_q;
  assign br_taken  = br_taken_q;
  assign br_target = br_target_q;
  assign trap      = (state_q == TRAP);

`ifdef RETIRE_COUNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt_q <= '0;
    else if (acc) cnt_q <= cnt_q + 16'd1;
  end

  assign retire_cnt = cnt_q;
`endif
endmodule
